// File: rtl/uart_rx.sv
// ---------------------------------------------------------------------------
// uart_rx -- 8N1 UART receiver
//
// Recovers one byte per frame from an asynchronous serial line. The line is
// resynchronised with two flops, start bits are qualified at their centre to
// reject glitches, and every data/stop bit is sampled one bit period after
// that centre point. Good frames deliver rx_byte with a one-cycle valid
// strobe; a low stop bit gives a one-cycle frame_err strobe instead. After
// that, the receiver waits for the line to return high before it re-arms.
//
// Parameters:
//   CLK_PER_BAUD  clock cycles per bit (minimum 8)
//
// Ports:
//   clk        system clock
//   rst        asynchronous active-low reset
//   rx         serial input, idle high, asynchronous to clk
//   rx_byte    last correctly received byte
//   valid      one-cycle pulse, rx_byte updated this cycle
//   frame_err  one-cycle pulse, stop bit sampled low
//   busy       high from start detection until return to IDLE
// ---------------------------------------------------------------------------
module uart_rx #(
   parameter int CLK_PER_BAUD = 2604
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx,
   output logic [7:0] rx_byte,
   output logic       valid,
   output logic       frame_err,
   output logic       busy
);

   localparam int CNT_W = $clog2(CLK_PER_BAUD);

   // Terminal counts: start-bit centre and one full bit period.
   localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLK_PER_BAUD / 2 - 1);
   localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLK_PER_BAUD - 1);

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      STOP,
      WAIT_HIGH
   } state_t;

   state_t           state, state_n;
   logic [CNT_W-1:0] cnt, cnt_n;
   logic [2:0]       bit_idx, bit_idx_n;
   logic [7:0]       shift, shift_n;
   logic [7:0]       rx_byte_n;
   logic             valid_n, frame_err_n;
   logic             rx_meta, rx_s;

   // -----------------------------------------------------------------------
   // Input synchroniser. Both flops reset to the idle (high) line level so
   // that leaving reset never looks like a start bit.
   // -----------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rx_meta <= 1'b1;
         rx_s    <= 1'b1;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every flop
         // samples the pre-edge value of the others; blocking here would
         // collapse the two synchroniser stages into one.
         rx_meta <= rx;
         rx_s    <= rx_meta;
      end
   end

   // -----------------------------------------------------------------------
   // State and datapath registers
   // -----------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         cnt       <= '0;
         bit_idx   <= '0;
         shift     <= '0;
         rx_byte   <= 8'h00;
         valid     <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         state     <= state_n;
         cnt       <= cnt_n;
         bit_idx   <= bit_idx_n;
         shift     <= shift_n;
         rx_byte   <= rx_byte_n;
         valid     <= valid_n;
         frame_err <= frame_err_n;
      end
   end

   // -----------------------------------------------------------------------
   // Next-state and next-datapath logic
   // -----------------------------------------------------------------------
   always_comb begin
      // NOTE: every output of this block gets a default first, so no path
      // through the case statement can leave a value held and infer a latch.
      state_n     = state;
      cnt_n       = cnt;
      bit_idx_n   = bit_idx;
      shift_n     = shift;
      rx_byte_n   = rx_byte;
      valid_n     = 1'b0;
      frame_err_n = 1'b0;

      unique case (state)
         IDLE: begin
            if (!rx_s) begin
               state_n = START;
               cnt_n   = '0;
            end
         end

         START: begin
            if (cnt == HALF_LAST) begin
               cnt_n = '0;
               // Line back high at the centre: treat as noise, not a frame.
               if (rx_s) begin
                  state_n = IDLE;
               end else begin
                  state_n   = DATA;
                  bit_idx_n = '0;
               end
            end else begin
               cnt_n = cnt + 1'b1;
            end
         end

         DATA: begin
            if (cnt == BIT_LAST) begin
               cnt_n            = '0;
               shift_n[bit_idx] = rx_s;
               if (bit_idx == 3'd7) begin
                  state_n = STOP;
               end else begin
                  bit_idx_n = bit_idx + 3'd1;
               end
            end else begin
               cnt_n = cnt + 1'b1;
            end
         end

         STOP: begin
            if (cnt == BIT_LAST) begin
               cnt_n = '0;
               // Leaving at mid-stop-bit leaves half a bit to catch a
               // back-to-back start edge; the stop bit itself reads high.
               if (rx_s) begin
                  state_n   = IDLE;
                  rx_byte_n = shift;
                  valid_n   = 1'b1;
               end else begin
                  state_n     = WAIT_HIGH;
                  frame_err_n = 1'b1;
               end
            end else begin
               cnt_n = cnt + 1'b1;
            end
         end

         WAIT_HIGH: begin
            // A held-low (break) line must not be seen as a stream of frames.
            if (rx_s) begin
               state_n = IDLE;
            end
         end

         default: begin
            state_n = IDLE;
            cnt_n   = '0;
         end
      endcase
   end

   // busy follows the registered state, so it drops on the same edge that
   // raises valid.
   assign busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// ---------------------------------------------------------------------------
// tb_uart_rx -- directed self-checking bench for uart_rx (CLK_PER_BAUD = 16)
//
// The bench drives the serial line on falling clock edges and a monitor
// watches DUT outputs on falling edges, logging valid/frame_err pulses,
// busy rising edges and pulse timestamps. Each scenario task compares the
// logged activity against hand-computed expectations.
// ---------------------------------------------------------------------------
module tb_uart_rx;

   localparam int CPB     = 16;
   // rx fall -> valid: 2 sync + CPB/2 + 9*CPB + 1 = 155
   localparam int LATENCY = 2 + CPB / 2 + 9 * CPB + 1;
   localparam int FRAME   = 10 * CPB;

   logic       clk;
   logic       rst;
   logic       rx;
   logic [7:0] rx_byte;
   logic       valid;
   logic       frame_err;
   logic       busy;

   int vectors;
   int miscompares;

   // Monitor state
   int         cycle;
   int         valid_cnt;
   int         ferr_cnt;
   int         busy_rise_cnt;
   int         overlap_cnt;
   int         busy_at_valid_cnt;
   int         bad_loop_byte_cnt;
   int         last_valid_cycle;
   int         prev_valid_cycle;
   logic [7:0] last_byte;
   logic [7:0] prev_byte;
   logic       busy_q;
   logic       loop_mode;
   int         start_cycle;

   uart_rx #(.CLK_PER_BAUD(CPB)) dut (
      .clk       (clk),
      .rst       (rst),
      .rx        (rx),
      .rx_byte   (rx_byte),
      .valid     (valid),
      .frame_err (frame_err),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cycle <= cycle + 1;

   always @(negedge clk) begin
      if (valid) begin
         valid_cnt        = valid_cnt + 1;
         prev_valid_cycle = last_valid_cycle;
         last_valid_cycle = cycle;
         prev_byte        = last_byte;
         last_byte        = rx_byte;
         if (busy) busy_at_valid_cnt = busy_at_valid_cnt + 1;
         if (loop_mode && rx_byte !== 8'h30) bad_loop_byte_cnt = bad_loop_byte_cnt + 1;
      end
      if (frame_err) ferr_cnt = ferr_cnt + 1;
      if (valid && frame_err) overlap_cnt = overlap_cnt + 1;
      if (busy && !busy_q) busy_rise_cnt = busy_rise_cnt + 1;
      busy_q = busy;
   end

   // Drive one bit for a full bit period, changing rx on a falling edge.
   task automatic drive_bit(input logic b);
      @(negedge clk);
      rx = b;
      repeat (CPB - 1) @(negedge clk);
   endtask

   task automatic send_frame(input logic [7:0] data, input logic stop_bit);
      @(negedge clk);
      rx          = 1'b0;
      start_cycle = cycle;
      repeat (CPB - 1) @(negedge clk);
      for (int i = 0; i < 8; i++) drive_bit(data[i]);
      drive_bit(stop_bit);
   endtask

   task automatic idle_cycles(input int n);
      @(negedge clk);
      rx = 1'b1;
      repeat (n) @(negedge clk);
   endtask

   task automatic test_reset;
      rst = 1'b0;
      rx  = 1'b1;
      repeat (4) @(negedge clk);
      vectors++;
      if (rx_byte !== 8'h00) begin
         miscompares++;
         $display("FAIL reset_rx_byte: got %h expected 00", rx_byte);
      end
      vectors++;
      if (valid !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_valid: got %b expected 0", valid);
      end
      vectors++;
      if (frame_err !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_frame_err: got %b expected 0", frame_err);
      end
      vectors++;
      if (busy !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_busy: got %b expected 0", busy);
      end
      rst = 1'b1;
      repeat (4) @(negedge clk);
   endtask

   task automatic test_single_frame;
      int v0, f0, lat;
      v0 = valid_cnt;
      f0 = ferr_cnt;
      send_frame(8'h30, 1'b1);
      idle_cycles(CPB);
      lat = last_valid_cycle - start_cycle;
      vectors++;
      if (valid_cnt - v0 !== 1) begin
         miscompares++;
         $display("FAIL single_valid_count: got %0d expected 1", valid_cnt - v0);
      end
      vectors++;
      if (last_byte !== 8'h30) begin
         miscompares++;
         $display("FAIL single_byte: got %h expected 30", last_byte);
      end
      vectors++;
      if (ferr_cnt - f0 !== 0) begin
         miscompares++;
         $display("FAIL single_frame_err: got %0d pulses expected 0", ferr_cnt - f0);
      end
      vectors++;
      if (busy_at_valid_cnt !== 0) begin
         miscompares++;
         $display("FAIL single_busy_drop: busy high at %0d valid pulses expected 0", busy_at_valid_cnt);
      end
      vectors++;
      if (lat < LATENCY - 1 || lat > LATENCY + 1) begin
         miscompares++;
         $display("FAIL single_latency: got %0d expected %0d+-1", lat, LATENCY);
      end
   endtask

   task automatic test_back_to_back;
      int v0, f0, gap;
      v0 = valid_cnt;
      f0 = ferr_cnt;
      send_frame(8'h55, 1'b1);
      send_frame(8'hA5, 1'b1);
      idle_cycles(CPB);
      gap = last_valid_cycle - prev_valid_cycle;
      vectors++;
      if (valid_cnt - v0 !== 2) begin
         miscompares++;
         $display("FAIL b2b_valid_count: got %0d expected 2", valid_cnt - v0);
      end
      vectors++;
      if (prev_byte !== 8'h55) begin
         miscompares++;
         $display("FAIL b2b_first_byte: got %h expected 55", prev_byte);
      end
      vectors++;
      if (last_byte !== 8'hA5) begin
         miscompares++;
         $display("FAIL b2b_second_byte: got %h expected a5", last_byte);
      end
      vectors++;
      if (gap < FRAME - 2 || gap > FRAME + 2) begin
         miscompares++;
         $display("FAIL b2b_spacing: got %0d expected %0d+-2", gap, FRAME);
      end
      vectors++;
      if (ferr_cnt - f0 !== 0) begin
         miscompares++;
         $display("FAIL b2b_frame_err: got %0d pulses expected 0", ferr_cnt - f0);
      end
   endtask

   task automatic test_glitch;
      int v0, f0, b0;
      v0 = valid_cnt;
      f0 = ferr_cnt;
      b0 = busy_rise_cnt;
      @(negedge clk);
      rx = 1'b0;
      repeat (4) @(negedge clk);
      rx = 1'b1;
      repeat (3 * CPB) @(negedge clk);
      vectors++;
      if (busy_rise_cnt - b0 !== 1) begin
         miscompares++;
         $display("FAIL glitch_busy_pulse: got %0d busy rises expected 1", busy_rise_cnt - b0);
      end
      vectors++;
      if (busy !== 1'b0) begin
         miscompares++;
         $display("FAIL glitch_busy_idle: got %b expected 0", busy);
      end
      vectors++;
      if (valid_cnt - v0 !== 0) begin
         miscompares++;
         $display("FAIL glitch_valid: got %0d pulses expected 0", valid_cnt - v0);
      end
      vectors++;
      if (ferr_cnt - f0 !== 0) begin
         miscompares++;
         $display("FAIL glitch_frame_err: got %0d pulses expected 0", ferr_cnt - f0);
      end
   endtask

   task automatic test_frame_error;
      int v0, f0, b0;
      v0 = valid_cnt;
      f0 = ferr_cnt;
      b0 = busy_rise_cnt;
      send_frame(8'h3C, 1'b0);
      repeat (40) @(negedge clk);   // line still low
      vectors++;
      if (ferr_cnt - f0 !== 1) begin
         miscompares++;
         $display("FAIL ferr_pulse_count: got %0d expected 1", ferr_cnt - f0);
      end
      vectors++;
      if (busy !== 1'b1) begin
         miscompares++;
         $display("FAIL ferr_wait_high_busy: got %b expected 1", busy);
      end
      vectors++;
      if (rx_byte !== 8'hA5) begin
         miscompares++;
         $display("FAIL ferr_rx_byte_held: got %h expected a5", rx_byte);
      end
      idle_cycles(3 * CPB);
      vectors++;
      if (busy !== 1'b0) begin
         miscompares++;
         $display("FAIL ferr_release_busy: got %b expected 0", busy);
      end
      vectors++;
      if (busy_rise_cnt - b0 !== 1) begin
         miscompares++;
         $display("FAIL ferr_no_retrigger: got %0d busy rises expected 1", busy_rise_cnt - b0);
      end
      vectors++;
      if (valid_cnt - v0 !== 0) begin
         miscompares++;
         $display("FAIL ferr_valid: got %0d pulses expected 0", valid_cnt - v0);
      end
   endtask

   task automatic test_reset_mid_frame;
      int v0, f0;
      v0 = valid_cnt;
      f0 = ferr_cnt;
      // Start of a 0xFF frame, then reset halfway through data bit 4.
      @(negedge clk);
      rx = 1'b0;
      repeat (CPB - 1) @(negedge clk);
      for (int i = 0; i < 4; i++) drive_bit(1'b1);
      @(negedge clk);
      rx = 1'b1;
      repeat (CPB / 2) @(negedge clk);
      vectors++;
      if (busy !== 1'b1) begin
         miscompares++;
         $display("FAIL rst_mid_busy_before: got %b expected 1", busy);
      end
      rst = 1'b0;
      repeat (3) @(negedge clk);
      vectors++;
      if (rx_byte !== 8'h00) begin
         miscompares++;
         $display("FAIL rst_mid_rx_byte: got %h expected 00", rx_byte);
      end
      rst = 1'b1;
      repeat (8 * CPB) @(negedge clk);   // rest of aborted frame (all high)
      vectors++;
      if (valid_cnt - v0 !== 0 || ferr_cnt - f0 !== 0) begin
         miscompares++;
         $display("FAIL rst_mid_no_pulse: got valid %0d frame_err %0d expected 0 0",
                  valid_cnt - v0, ferr_cnt - f0);
      end
      vectors++;
      if (rx_byte !== 8'h00 || busy !== 1'b0) begin
         miscompares++;
         $display("FAIL rst_mid_idle: got rx_byte %h busy %b expected 00 0", rx_byte, busy);
      end
      send_frame(8'h12, 1'b1);
      idle_cycles(CPB);
      vectors++;
      if (valid_cnt - v0 !== 1 || last_byte !== 8'h12) begin
         miscompares++;
         $display("FAIL rst_mid_next_frame: got %0d pulses byte %h expected 1 12",
                  valid_cnt - v0, last_byte);
      end
   endtask

   task automatic test_loopback;
      int v0, f0;
      v0        = valid_cnt;
      f0        = ferr_cnt;
      loop_mode = 1'b1;
      for (int n = 0; n < 10; n++) send_frame(8'h30, 1'b1);
      idle_cycles(CPB);
      loop_mode = 1'b0;
      vectors++;
      if (valid_cnt - v0 !== 10) begin
         miscompares++;
         $display("FAIL loop_valid_count: got %0d expected 10", valid_cnt - v0);
      end
      vectors++;
      if (bad_loop_byte_cnt !== 0) begin
         miscompares++;
         $display("FAIL loop_bytes: got %0d wrong bytes expected 0", bad_loop_byte_cnt);
      end
      vectors++;
      if (ferr_cnt - f0 !== 0) begin
         miscompares++;
         $display("FAIL loop_frame_err: got %0d pulses expected 0", ferr_cnt - f0);
      end
   endtask

   task automatic test_exclusive_pulses;
      vectors++;
      if (overlap_cnt !== 0) begin
         miscompares++;
         $display("FAIL valid_frame_err_overlap: got %0d cycles expected 0", overlap_cnt);
      end
   endtask

   initial begin
      vectors           = 0;
      miscompares       = 0;
      cycle             = 0;
      valid_cnt         = 0;
      ferr_cnt          = 0;
      busy_rise_cnt     = 0;
      overlap_cnt       = 0;
      busy_at_valid_cnt = 0;
      bad_loop_byte_cnt = 0;
      last_valid_cycle  = 0;
      prev_valid_cycle  = 0;
      last_byte         = 8'h00;
      prev_byte         = 8'h00;
      busy_q            = 1'b0;
      loop_mode         = 1'b0;
      start_cycle       = 0;

      test_reset();
      test_single_frame();
      test_back_to_back();
      test_glitch();
      test_frame_error();
      test_reset_mid_frame();
      test_loopback();
      test_exclusive_pulses();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- 8N1 UART receiver. Sits downstream of the uart transmitter: it consumes a serial line (loopback of uart_tx, or the board RX pin) and delivers one parallel byte per frame.
- Feeds the byte to application logic with a single-cycle valid strobe. It also reports framing errors.
- Shares its bit timing with the transmitter through the same CLK_PER_BAUD parameter.

Parameters:
- CLK_PER_BAUD, 2604, clock cycles per bit (25_000_000 / 9600). Minimum legal value is 8.
- CNT_W, $clog2(CLK_PER_BAUD), width of the bit-timing counter. Derived; never overridden.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous, active-low reset
- rx  input  1  serial input, idle high, asynchronous to clk
- rx_byte  output  8  last correctly received byte
- valid  output  1  one-cycle pulse; rx_byte updated this cycle
- frame_err  output  1  one-cycle pulse; stop bit sampled low
- busy  output  1  high from start detection until return to IDLE

Behaviour:
- Reset (rst low, asynchronous): state=IDLE; counters=0; rx_byte=8'h00; valid=0; frame_err=0; busy=0; synchronizer flops=1.
- Input sync: rx passes through a 2-flop synchronizer (rx_s). All decisions use rx_s only. The 2-cycle sync delay is part of the latency.
- FSM states: IDLE, START, DATA, STOP, WAIT_HIGH.
- IDLE: when rx_s==0, go to START, load cnt=0, set busy=1.
- START:
  - Count to CLK_PER_BAUD/2 - 1 (integer divide); this is the start-bit centre.
  - If rx_s==1 at the centre, it is a glitch: return to IDLE, busy=0, no pulse.
  - Otherwise go to DATA with bit_idx=0 and cnt=0.
- DATA:
  - Each time cnt reaches CLK_PER_BAUD-1, sample rx_s into shift[bit_idx] (LSB first) and reset cnt.
  - After bit_idx=7 is sampled, go to STOP.
- STOP:
  - At cnt==CLK_PER_BAUD-1, sample rx_s.
  - If 1: next cycle rx_byte<=shift, valid=1 for exactly one cycle, state IDLE, busy=0.
  - If 0: frame_err=1 for one cycle, rx_byte unchanged, state WAIT_HIGH.
- WAIT_HIGH: stay until rx_s==1, then IDLE, busy=0. This prevents a held-low line (break) from retriggering frames.
- Latency: valid rises 2 + (CLK_PER_BAUD/2) + 9*CLK_PER_BAUD + 1 cycles (±1) after the rx falling edge.
- Back-to-back frames: returning to IDLE at mid-stop-bit lets the next start bit be caught immediately. The stop bit still reads high, so no false trigger occurs.
- valid and frame_err are never high in the same cycle.
- There is no backpressure. rx_byte holds its value until the next valid frame, and the consumer must capture it on valid.
- Reset mid-frame discards the partial byte. No pulse is produced, and rx_byte returns to 8'h00.
- Counter arithmetic is unsigned in CNT_W bits. It never wraps, because cnt resets at the terminal value.

Test Plan (CLK_PER_BAUD=16 for speed; stimulus is a bench-driven serial line):
- Single frame 0x30 ("0") sent with correct timing -> valid pulses exactly once, rx_byte=8'h30, frame_err stays 0, busy drops the same cycle valid rises.
- Back-to-back 0x55 then 0xA5 with no idle gap -> two valid pulses 160±2 cycles apart, rx_byte=8'h55 then 8'hA5.
- Glitch: rx low for 4 cycles, then high -> busy pulses, returns to IDLE, no valid, no frame_err.
- Framing error: 0x3C with stop bit low, then line held low 40 cycles, then high -> one frame_err pulse, rx_byte keeps its previous value, no retrigger until the line goes high.
- Reset mid-frame: assert rst low during DATA bit 4 of 0xFF, release, then send 0x12 -> no pulse for the aborted frame, rx_byte=8'h00 after reset, then 8'h12 with valid.
- Loopback with the uart transmitter, tx_byte="0" and start_send held at 1 -> continuous valid pulses every frame with rx_byte=8'h30, frame_err never asserted over 10 frames.
